// File: rtl/hazard_fwd_unit_if.sv
`default_nettype none
// =============================================================================
// hazard_fwd_unit_if : ID-side hazard/forwarding bundle for hazard_fwd_unit
// Rev 1.0
// =============================================================================
interface hazard_fwd_unit_if #(
  parameter int REG_AW = 5,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
);
  localparam int FSEL_W = $clog2(STAGES);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_wen;
  logic              id_load;
  logic              id_store;
  logic              mem_hold;
  logic              redirect;

  logic              stall;
  logic              bubble;
  logic              flush;
  logic [FSEL_W-1:0] fwd_a;
  logic [FSEL_W-1:0] fwd_b;
  logic [FSEL_W-1:0] fwd_st;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_wen, id_load, id_store, mem_hold, redirect,
    input  stall, bubble, flush, fwd_a, fwd_b, fwd_st, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_wen, id_load, id_store, mem_hold, redirect,
    output stall, bubble, flush, fwd_a, fwd_b, fwd_st, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// =============================================================================
// hazard_fwd_unit : parametrised hazard / forwarding controller (EX..WB tracker)
// Rev 1.0
// =============================================================================
module hazard_fwd_unit #(
  parameter int REG_AW         = 5,
  parameter int STAGES         = 3,
  parameter int LOAD_READY     = 2,
  parameter int REDIRECT_STAGE = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_fwd_unit_if.slave pipe
);

  localparam int FSEL_W = $clog2(STAGES);

  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_HOLD  = 2'd1;
  localparam logic [1:0] MODE_REDIR = 2'd2;
  localparam logic [1:0] MODE_LU    = 2'd3;

  // Per-stage tracker; stage 0 is EX, STAGES-1 is WB.
  logic [STAGES-1:0] st_valid;
  logic [STAGES-1:0] st_wen;
  logic [STAGES-1:0] st_load;
  logic [REG_AW-1:0] st_rd [STAGES];

  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic              ex_use1;
  logic              ex_use2;
  logic              ex_store;

  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  logic [STAGES-1:0] hit_rs1;
  logic [STAGES-1:0] hit_rs2;
  logic [STAGES-1:0] lu_hit;
  logic              load_use;
  logic [1:0]        mode;
  logic [FSEL_W-1:0] sel_rs1;
  logic [FSEL_W-1:0] sel_rs2;

  // Stage 0 never forwards to itself.
  assign hit_rs1[0] = 1'b0;
  assign hit_rs2[0] = 1'b0;

  for (genvar k = 1; k < STAGES; k++) begin : g_match
    localparam bit RESULT_READY_FOR_LOAD = (k >= LOAD_READY);
    logic producer;
    assign producer   = st_valid[k] && st_wen[k] && (st_rd[k] != '0)
                        && (!st_load[k] || RESULT_READY_FOR_LOAD);
    assign hit_rs1[k] = producer && st_valid[0] && ex_use1 && (st_rd[k] == ex_rs1);
    assign hit_rs2[k] = producer && st_valid[0] && ex_use2 && (st_rd[k] == ex_rs2);
  end

  // A load in a stage below LOAD_READY-1 cannot reach its consumer in time.
  for (genvar s = 0; s < STAGES; s++) begin : g_lu
    if (s + 2 <= LOAD_READY) begin : g_on
      assign lu_hit[s] = st_valid[s] && st_load[s] && st_wen[s] && (st_rd[s] != '0)
                         && ((pipe.id_use_rs1 && (st_rd[s] == pipe.id_rs1))
                          || (pipe.id_use_rs2 && (st_rd[s] == pipe.id_rs2)));
    end else begin : g_off
      assign lu_hit[s] = 1'b0;
    end
  end

  assign load_use = pipe.id_valid && (|lu_hit);

  // Youngest producer wins: scan oldest to youngest so the last hit sticks.
  function automatic logic [FSEL_W-1:0] youngest(input logic [STAGES-1:0] hit);
    logic [FSEL_W-1:0] sel;
    sel = '0;
    for (int k = STAGES - 1; k >= 1; k--) begin
      if (hit[k]) sel = FSEL_W'(k);
    end
    return sel;
  endfunction

  assign sel_rs1 = youngest(hit_rs1);
  assign sel_rs2 = youngest(hit_rs2);

  always_comb begin
    mode = MODE_RUN;
    if (pipe.mem_hold)      mode = MODE_HOLD;
    else if (pipe.redirect) mode = MODE_REDIR;
    else if (load_use)      mode = MODE_LU;
  end

  always_comb begin
    pipe.stall  = 1'b0;
    pipe.bubble = 1'b0;
    pipe.flush  = 1'b0;
    case (mode)
      MODE_HOLD:  pipe.stall = 1'b1;
      MODE_REDIR: begin
        pipe.flush  = 1'b1;
        pipe.bubble = 1'b1;
      end
      MODE_LU: begin
        pipe.stall  = 1'b1;
        pipe.bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign pipe.fwd_a     = sel_rs1;
  assign pipe.fwd_b     = ex_store ? '0 : sel_rs2;
  assign pipe.fwd_st    = ex_store ? sel_rs2 : '0;
  assign pipe.stall_cnt = stall_cnt;
  assign pipe.flush_cnt = flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_valid  <= '0;
      st_wen    <= '0;
      st_load   <= '0;
      for (int k = 0; k < STAGES; k++) st_rd[k] <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_use1   <= 1'b0;
      ex_use2   <= 1'b0;
      ex_store  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (mode != MODE_HOLD) begin
      // Wrong-path entries younger than the redirecting stage die as they move.
      for (int k = 1; k < STAGES; k++) begin
        st_valid[k] <= st_valid[k-1] && !((mode == MODE_REDIR) && (k - 1 < REDIRECT_STAGE));
        st_wen[k]   <= st_wen[k-1];
        st_load[k]  <= st_load[k-1];
        st_rd[k]    <= st_rd[k-1];
      end
      st_valid[0] <= (mode == MODE_RUN) && pipe.id_valid;
      st_wen[0]   <= pipe.id_wen;
      st_load[0]  <= pipe.id_load;
      st_rd[0]    <= pipe.id_rd;
      ex_rs1      <= pipe.id_rs1;
      ex_rs2      <= pipe.id_rs2;
      ex_use1     <= pipe.id_use_rs1;
      ex_use2     <= pipe.id_use_rs2;
      ex_store    <= pipe.id_store;
      if ((mode == MODE_LU) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((mode == MODE_REDIR) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
